msg_buffer_arbiter: RTL and testbench



---
 rtl/msg_buffer_arbiter.sv | 184 ++++++++++++++++++
 tb/tb_msg_buffer_arbiter.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/msg_buffer_arbiter.sv
// Shared single-port message buffer: arbitrates one character array between
// display reads (highest priority), decoder appends and the outbound send engine.
module msg_buffer_arbiter #(
    parameter int unsigned DEPTH = 32,
    parameter int unsigned AW    = 5,
    parameter int unsigned CW    = 8
) (
    input  logic          cclk,
    input  logic          rstb,
    input  logic          wr_stb,
    input  logic [CW-1:0] wr_char,
    output logic          wr_drop,
    input  logic          clr_stb,
    input  logic          disp_req,
    input  logic [AW-1:0] disp_addr,
    output logic          disp_valid,
    output logic [CW-1:0] disp_data,
    input  logic          snd_stb,
    output logic          tx_valid,
    output logic [CW-1:0] tx_data,
    input  logic          tx_ready,
    output logic          snd_done,
    output logic          busy,
    output logic [AW:0]   count
);

    localparam int unsigned CNTW = AW + 1;
    localparam logic [AW:0] FULL = CNTW'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RD,
        S_OUT,
        S_DONE
    } state_e;

    state_e        state_q,     state_d;
    logic [AW:0]   count_q,     count_d;
    logic [AW-1:0] rd_ptr_q,    rd_ptr_d;
    logic          pend_vld_q,  pend_vld_d;
    logic [CW-1:0] pend_char_q, pend_char_d;
    logic          disp_vld_q,  disp_vld_d;
    logic [CW-1:0] disp_data_q, disp_data_d;
    logic          tx_valid_q,  tx_valid_d;
    logic [CW-1:0] tx_data_q,   tx_data_d;
    logic          wr_drop_q,   wr_drop_d;
    logic          snd_done_q,  snd_done_d;
    logic          busy_q,      busy_d;

    logic          idle;
    logic          clr_en;
    logic          mem_we;
    logic [CW-1:0] mem_q [DEPTH];

    // Message storage; contents are never cleared, only masked by count.
    always_ff @(posedge cclk) begin
        if (mem_we) begin
            mem_q[count_q[AW-1:0]] <= pend_char_q;
        end
    end

    always_ff @(posedge cclk) begin
        if (!rstb) begin
            state_q     <= S_IDLE;
            count_q     <= '0;
            rd_ptr_q    <= '0;
            pend_vld_q  <= 1'b0;
            pend_char_q <= '0;
            disp_vld_q  <= 1'b0;
            disp_data_q <= '0;
            tx_valid_q  <= 1'b0;
            tx_data_q   <= '0;
            wr_drop_q   <= 1'b0;
            snd_done_q  <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            rd_ptr_q    <= rd_ptr_d;
            pend_vld_q  <= pend_vld_d;
            pend_char_q <= pend_char_d;
            disp_vld_q  <= disp_vld_d;
            disp_data_q <= disp_data_d;
            tx_valid_q  <= tx_valid_d;
            tx_data_q   <= tx_data_d;
            wr_drop_q   <= wr_drop_d;
            snd_done_q  <= snd_done_d;
            busy_q      <= busy_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        rd_ptr_d    = rd_ptr_q;
        pend_vld_d  = pend_vld_q;
        pend_char_d = pend_char_q;
        tx_valid_d  = tx_valid_q;
        tx_data_d   = tx_data_q;
        wr_drop_d   = 1'b0;
        snd_done_d  = 1'b0;
        mem_we      = 1'b0;
        idle        = (state_q == S_IDLE);
        clr_en      = clr_stb && idle;

        // Display port owns the array whenever it asks.
        disp_vld_d  = disp_req;
        disp_data_d = '0;
        if (disp_req && ({1'b0, disp_addr} < count_q)) begin
            disp_data_d = mem_q[disp_addr];
        end

        // Clear beats a same-cycle commit, which is discarded silently.
        if (clr_en) begin
            count_d    = '0;
            pend_vld_d = 1'b0;
        end else if (pend_vld_q && !disp_req && idle) begin
            pend_vld_d = 1'b0;
            if (count_q < FULL) begin
                mem_we  = 1'b1;
                count_d = count_q + CNTW'(1);
            end else begin
                wr_drop_d = 1'b1;
            end
        end

        if (wr_stb) begin
            if (pend_vld_q) begin
                wr_drop_d = 1'b1;
            end else begin
                pend_vld_d  = 1'b1;
                pend_char_d = wr_char;
            end
        end

        case (state_q)
            S_IDLE: begin
                // count_d already includes a same-cycle commit.
                if (snd_stb && !clr_en && (count_d != '0)) begin
                    rd_ptr_d = '0;
                    state_d  = S_RD;
                end
            end
            S_RD: begin
                if (!disp_req) begin
                    tx_data_d  = mem_q[rd_ptr_q];
                    tx_valid_d = 1'b1;
                    state_d    = S_OUT;
                end
            end
            S_OUT: begin
                if (tx_valid_q && tx_ready) begin
                    tx_valid_d = 1'b0;
                    if ({1'b0, rd_ptr_q} == (count_q - CNTW'(1))) begin
                        state_d = S_DONE;
                    end else begin
                        rd_ptr_d = rd_ptr_q + AW'(1);
                        state_d  = S_RD;
                    end
                end
            end
            S_DONE: begin
                count_d    = '0;
                snd_done_d = 1'b1;
                state_d    = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

    assign wr_drop    = wr_drop_q;
    assign disp_valid = disp_vld_q;
    assign disp_data  = disp_data_q;
    assign tx_valid   = tx_valid_q;
    assign tx_data    = tx_data_q;
    assign snd_done   = snd_done_q;
    assign busy       = busy_q;
    assign count      = count_q;

endmodule

// File: tb/tb_msg_buffer_arbiter.sv
// Bench for msg_buffer_arbiter: directed scenarios plus randomized rounds checked
// against a queue-based model of the stored message.
module tb_msg_buffer_arbiter;

    logic       cclk;
    logic       rstb;
    logic       wr_stb;
    logic [7:0] wr_char;
    logic       wr_drop;
    logic       clr_stb;
    logic       disp_req;
    logic [4:0] disp_addr;
    logic       disp_valid;
    logic [7:0] disp_data;
    logic       snd_stb;
    logic       tx_valid;
    logic [7:0] tx_data;
    logic       tx_ready;
    logic       snd_done;
    logic       busy;
    logic [5:0] count;

    int checks = 0;
    int errors = 0;
    int drop_cnt = 0;
    int done_cnt = 0;
    int stall_err;
    int skip_err;
    int data_err;
    logic [7:0] model_q[$];
    logic [7:0] got[$];

    msg_buffer_arbiter #(.DEPTH(32), .AW(5), .CW(8)) dut (
        .cclk(cclk), .rstb(rstb), .wr_stb(wr_stb), .wr_char(wr_char), .wr_drop(wr_drop),
        .clr_stb(clr_stb), .disp_req(disp_req), .disp_addr(disp_addr),
        .disp_valid(disp_valid), .disp_data(disp_data), .snd_stb(snd_stb),
        .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
        .snd_done(snd_done), .busy(busy), .count(count)
    );

    initial cclk = 1'b0;
    always #5 cclk = ~cclk;

    // Pulse counters sampled mid-cycle; tasks work with deltas.
    always @(negedge cclk) begin
        if (wr_drop) drop_cnt++;
        if (snd_done) done_cnt++;
    end

    task automatic tick();
        @(posedge cclk);
        #1;
    endtask

    function automatic logic [7:0] exp_disp(input logic [4:0] a);
        if (int'(a) < model_q.size()) return model_q[a];
        return 8'h00;
    endfunction

    task automatic do_reset();
        wr_stb = 0; wr_char = 0; clr_stb = 0; disp_req = 0; disp_addr = 0;
        snd_stb = 0; tx_ready = 0; rstb = 0;
        tick(); tick();
        rstb = 1;
        model_q.delete();
    endtask

    task automatic write_char(input logic [7:0] c);
        wr_stb = 1; wr_char = c;
        tick();
        wr_stb = 0;
        tick(); tick();
    endtask

    // Pulses snd_stb and drives the send to completion, recording what was observed.
    task automatic run_send(input int ready_mode, input int disp_mode, output int ok);
        int base;
        logic prev_req, prev_v, prev_rdy, rdy, req;
        logic [4:0] prev_addr, addr;
        logic [7:0] prev_d;
        got.delete();
        stall_err = 0; skip_err = 0; data_err = 0; ok = 0;
        base = done_cnt;
        snd_stb = 1;
        tick();
        snd_stb = 0;
        prev_req = 0; prev_v = 0; prev_rdy = 0; prev_addr = 0; prev_d = 0;
        for (int c = 0; c < 400; c++) begin
            if (prev_req) begin
                if (!disp_valid) skip_err++;
                else if (disp_data !== exp_disp(prev_addr)) data_err++;
            end else if (disp_valid) begin
                skip_err++;
            end
            if (prev_v && !prev_rdy && (!tx_valid || tx_data !== prev_d)) stall_err++;
            if (done_cnt != base) begin
                ok = 1;
                break;
            end
            rdy  = (ready_mode == 0) ? (c % 3 == 2) : 1'($urandom_range(0, 1));
            req  = (disp_mode == 0) ? (c >= 4 && c < 9) : ($urandom_range(0, 2) == 0);
            addr = 5'($urandom);
            tx_ready = rdy; disp_req = req; disp_addr = addr;
            if (tx_valid && rdy) got.push_back(tx_data);
            prev_req = req; prev_addr = addr; prev_v = tx_valid; prev_d = tx_data; prev_rdy = rdy;
            tick();
        end
        tx_ready = 0; disp_req = 0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (count !== 6'd0) begin errors++; $display("FAIL reset_count got %0d exp 0", count); end
        checks++; if (busy !== 1'b0 || tx_valid !== 1'b0 || snd_done !== 1'b0 || wr_drop !== 1'b0) begin
            errors++; $display("FAIL reset_ctrl busy %b tx_valid %b snd_done %b wr_drop %b exp all 0", busy, tx_valid, snd_done, wr_drop); end
        checks++; if (disp_valid !== 1'b0 || disp_data !== 8'h00 || tx_data !== 8'h00) begin
            errors++; $display("FAIL reset_data disp_valid %b disp_data %h tx_data %h exp 0", disp_valid, disp_data, tx_data); end
    endtask

    task automatic test_append_readback();
        logic [7:0] exp_rd [4];
        exp_rd[0] = 8'h41; exp_rd[1] = 8'h42; exp_rd[2] = 8'h43; exp_rd[3] = 8'h00;
        do_reset();
        write_char(8'h41); write_char(8'h42); write_char(8'h43);
        checks++; if (count !== 6'd3) begin errors++; $display("FAIL append_count got %0d exp 3", count); end
        disp_req = 1;
        for (int a = 0; a < 4; a++) begin
            disp_addr = 5'(a);
            tick();
            checks++; if (disp_valid !== 1'b1 || disp_data !== exp_rd[a]) begin
                errors++; $display("FAIL readback_%0d valid %b data %h exp 1 %h", a, disp_valid, disp_data, exp_rd[a]); end
        end
        disp_req = 0;
        tick();
        checks++; if (disp_valid !== 1'b0) begin errors++; $display("FAIL readback_idle valid %b exp 0", disp_valid); end
    endtask

    task automatic test_overflow();
        int base;
        do_reset();
        base = drop_cnt;
        for (int i = 0; i < 33; i++) write_char(8'(8'h60 + i));
        checks++; if (count !== 6'd32) begin errors++; $display("FAIL overflow_count got %0d exp 32", count); end
        checks++; if (drop_cnt - base !== 1) begin errors++; $display("FAIL overflow_drops got %0d exp 1", drop_cnt - base); end
        disp_req = 1; disp_addr = 5'd31;
        tick();
        checks++; if (disp_data !== 8'h7f) begin errors++; $display("FAIL overflow_mem31 got %h exp 7f", disp_data); end
        disp_addr = 5'd0;
        tick();
        checks++; if (disp_data !== 8'h60) begin errors++; $display("FAIL overflow_mem0 got %h exp 60", disp_data); end
        disp_req = 0;
        tick();
    endtask

    task automatic test_send_contention();
        int ok, base;
        do_reset();
        write_char(8'h41); write_char(8'h42); write_char(8'h43);
        model_q = '{8'h41, 8'h42, 8'h43};
        base = done_cnt;
        run_send(0, 0, ok);
        checks++; if (ok !== 1) begin errors++; $display("FAIL send_timeout done %0d exp 1", ok); end
        checks++; if (got.size() !== 3 || got[0] !== 8'h41 || got[1] !== 8'h42 || got[2] !== 8'h43) begin
            errors++; $display("FAIL send_seq got %0d chars exp 41 42 43", got.size()); end
        checks++; if (stall_err !== 0) begin errors++; $display("FAIL send_stable got %0d glitches exp 0", stall_err); end
        checks++; if (skip_err !== 0 || data_err !== 0) begin
            errors++; $display("FAIL send_disp skipped %0d wrong %0d exp 0 0", skip_err, data_err); end
        tick(); tick();
        checks++; if (done_cnt - base !== 1) begin errors++; $display("FAIL send_done_pulses got %0d exp 1", done_cnt - base); end
        checks++; if (count !== 6'd0 || busy !== 1'b0) begin
            errors++; $display("FAIL send_after count %0d busy %b exp 0 0", count, busy); end
    endtask

    task automatic test_write_during_send();
        int base_d, base_s, n;
        do_reset();
        write_char(8'h41); write_char(8'h42); write_char(8'h43);
        base_d = drop_cnt; base_s = done_cnt;
        snd_stb = 1; tick(); snd_stb = 0;
        n = 0;
        while (!tx_valid && n < 10) begin tick(); n++; end
        checks++; if (tx_valid !== 1'b1) begin errors++; $display("FAIL wds_out tx_valid %b exp 1", tx_valid); end
        wr_stb = 1; wr_char = 8'h45; tick(); wr_stb = 0;
        for (int i = 0; i < 3; i++) begin
            checks++; if (count !== 6'd3 || busy !== 1'b1) begin
                errors++; $display("FAIL wds_frozen count %0d busy %b exp 3 1", count, busy); end
            tick();
        end
        got.delete();
        tx_ready = 1; n = 0;
        while (done_cnt == base_s && n < 50) begin
            if (tx_valid) got.push_back(tx_data);
            tick(); n++;
        end
        tx_ready = 0;
        checks++; if (got.size() !== 3 || got[0] !== 8'h41 || got[2] !== 8'h43) begin
            errors++; $display("FAIL wds_seq got %0d chars exp 41 42 43", got.size()); end
        tick(); tick(); tick();
        checks++; if (count !== 6'd1) begin errors++; $display("FAIL wds_count got %0d exp 1", count); end
        disp_req = 1; disp_addr = 5'd0; tick(); disp_req = 0;
        checks++; if (disp_data !== 8'h45) begin errors++; $display("FAIL wds_mem0 got %h exp 45", disp_data); end
        checks++; if (drop_cnt - base_d !== 0) begin errors++; $display("FAIL wds_drops got %0d exp 0", drop_cnt - base_d); end
    endtask

    task automatic test_ignored_strobes();
        logic busy_seen;
        int base;
        do_reset();
        busy_seen = 0;
        snd_stb = 1; tick(); snd_stb = 0;
        for (int i = 0; i < 4; i++) begin busy_seen |= busy; tick(); end
        checks++; if (busy_seen !== 1'b0) begin errors++; $display("FAIL empty_send busy %b exp 0", busy_seen); end
        write_char(8'h31); write_char(8'h32);
        checks++; if (count !== 6'd2) begin errors++; $display("FAIL pre_clear count %0d exp 2", count); end
        clr_stb = 1; snd_stb = 1; tick(); clr_stb = 0; snd_stb = 0;
        for (int i = 0; i < 4; i++) begin busy_seen |= busy; tick(); end
        checks++; if (busy_seen !== 1'b0 || count !== 6'd0) begin
            errors++; $display("FAIL clr_snd busy %b count %0d exp 0 0", busy_seen, count); end
        base = drop_cnt;
        wr_stb = 1; wr_char = 8'h33; tick(); wr_stb = 0;
        clr_stb = 1; tick(); clr_stb = 0;
        tick(); tick();
        checks++; if (count !== 6'd0 || drop_cnt - base !== 0) begin
            errors++; $display("FAIL clr_commit count %0d drops %0d exp 0 0", count, drop_cnt - base); end
    endtask

    task automatic test_reset_mid_send();
        int n;
        do_reset();
        write_char(8'h41); write_char(8'h42); write_char(8'h43);
        snd_stb = 1; tick(); snd_stb = 0;
        n = 0;
        while (!tx_valid && n < 10) begin tick(); n++; end
        disp_req = 1; rstb = 0;
        tick();
        checks++; if (tx_valid !== 1'b0 || count !== 6'd0 || busy !== 1'b0 || disp_valid !== 1'b0) begin
            errors++; $display("FAIL mid_reset tx_valid %b count %0d busy %b disp_valid %b exp 0", tx_valid, count, busy, disp_valid); end
        rstb = 1; disp_req = 0;
        tick(); tick();
        checks++; if (tx_valid !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL post_reset tx_valid %b busy %b exp 0 0", tx_valid, busy); end
    endtask

    task automatic test_random();
        int base, exp_drops, ok, n, act, bad;
        logic [7:0] c;
        logic req, prev_req;
        logic [4:0] prev_addr;
        do_reset();
        for (int r = 0; r < 10; r++) begin
            n = $urandom_range(0, 12);
            base = drop_cnt; exp_drops = 0;
            for (int i = 0; i < n; i++) begin
                c = 8'($urandom);
                write_char(c);
                if (model_q.size() < 32) model_q.push_back(c);
                else exp_drops++;
            end
            checks++; if (int'(count) !== model_q.size()) begin
                errors++; $display("FAIL rnd%0d_count got %0d exp %0d", r, count, model_q.size()); end
            checks++; if (drop_cnt - base !== exp_drops) begin
                errors++; $display("FAIL rnd%0d_drops got %0d exp %0d", r, drop_cnt - base, exp_drops); end
            prev_req = 0; prev_addr = 0; bad = 0;
            for (int i = 0; i < 12; i++) begin
                req = 1'($urandom_range(0, 1));
                disp_req = req; disp_addr = 5'($urandom);
                tick();
                if (disp_valid !== req) bad++;
                else if (req && disp_data !== exp_disp(disp_addr)) bad++;
                prev_req = req; prev_addr = disp_addr;
            end
            disp_req = 0;
            checks++; if (bad !== 0) begin errors++; $display("FAIL rnd%0d_disp got %0d bad reads exp 0", r, bad); end
            act = $urandom_range(0, 2);
            if (act == 0 && model_q.size() > 0) begin
                run_send(1, 1, ok);
                bad = (got.size() != model_q.size()) ? 1 : 0;
                if (bad == 0) for (int i = 0; i < got.size(); i++) if (got[i] !== model_q[i]) bad++;
                checks++; if (ok !== 1 || bad !== 0 || stall_err !== 0 || skip_err !== 0 || data_err !== 0) begin
                    errors++; $display("FAIL rnd%0d_send done %0d sent %0d exp %0d bad %0d stall %0d skip %0d data %0d",
                        r, ok, got.size(), model_q.size(), bad, stall_err, skip_err, data_err); end
                model_q.delete();
                tick(); tick();
            end else if (act == 1) begin
                clr_stb = 1; tick(); clr_stb = 0; tick();
                model_q.delete();
            end
            checks++; if (int'(count) !== model_q.size()) begin
                errors++; $display("FAIL rnd%0d_post count %0d exp %0d", r, count, model_q.size()); end
        end
    endtask

    initial begin
        test_reset();
        test_append_readback();
        test_overflow();
        test_send_contention();
        test_write_during_send();
        test_ignored_strobes();
        test_reset_mid_send();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
